// File: rtl/program_counter_fetch.sv
// ============================================================================
// program_counter_fetch
//
// Purpose:
//   16-bit program counter with a fetch-side valid/ready handshake. The PC is
//   presented on 'out' to instruction memory; it advances by one (through an
//   Increment16 instance) when memory accepts the address and 'inc' permits
//   it. Priority per cycle: clear > load/call > ret > advance > hold. One
//   bubble (out_valid=0) is inserted after reset and after every redirect.
//
// Optional feature macro: PC_RETURN_STACK_EN
//   Defined   : a RAS_DEPTH x 16 return-address stack backs call/ret, and
//               ras_err reports push-when-full / pop-when-empty.
//   Undefined : call behaves exactly as load, ret is ignored, ras_err is 0,
//               and no stack storage exists.
//
// Parameters:
//   WIDTH        PC width (only 16 is legal, Increment16 is fixed width)
//   RESET_VECTOR PC value after reset and after clear
//   RAS_DEPTH    return-stack entries (used only with PC_RETURN_STACK_EN)
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   clear      in   1      synchronous clear to RESET_VECTOR, state BOOT
//   load       in   1      redirect to load_addr
//   load_addr  in   WIDTH  redirect / call target
//   inc        in   1      permit advance on handshake
//   out        out  WIDTH  current PC (fetch address)
//   out_valid  out  1      out is a fetchable address
//   out_ready  in   1      instruction memory accepts out this cycle
//   wrap       out  1      sticky: PC advanced from FFFF to 0000
//   call       in   1      push out+1 and redirect to load_addr
//   ret        in   1      pop return address into PC
//   ras_err    out  1      sticky: push when full or pop when empty
// ============================================================================

// Plain 16-bit incrementer; the carry out marks the FFFF -> 0000 wrap.
module Increment16 (
   input  logic [15:0] a_i,
   output logic [15:0] sum_o,
   output logic        carry_o
);

   // Widen by one bit so the carry falls out of the same addition.
   assign {carry_o, sum_o} = {1'b0, a_i} + 17'd1;

endmodule

module program_counter_fetch #(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int               RAS_DEPTH    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_addr,
   input  logic             inc,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             wrap,
   input  logic             call,
   input  logic             ret,
   output logic             ras_err
);

   // The incrementer is a fixed 16-bit block and the stack needs at least
   // one entry, so any other configuration is refused at elaboration.
   if (WIDTH != 16 || RAS_DEPTH < 1) begin : gBadParams
      $error("program_counter_fetch: WIDTH must be 16 and RAS_DEPTH >= 1");
   end

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             wrap_q, wrap_d;

   logic [WIDTH-1:0] pcPlusOne;
   logic             pcCarry;

   logic             accept;
   logic             redirect;
   logic             retReq;
   logic             pop;
   logic [WIDTH-1:0] popData;
   logic             advance;

   Increment16 uInc (
      .a_i     (pc_q),
      .sum_o   (pcPlusOne),
      .carry_o (pcCarry)
   );

   assign accept = out_valid & out_ready;

   // call is always a redirect; with the stack enabled it also pushes.
   assign redirect = ~clear & (load | call);

`ifdef PC_RETURN_STACK_EN

   localparam int SPW  = $clog2(RAS_DEPTH + 1);
   localparam int IDXW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

   logic [WIDTH-1:0] ras_q [RAS_DEPTH];
   logic [SPW-1:0]   sp_q, sp_d;
   logic             rasErr_q, rasErr_d;

   logic             rasFull;
   logic             rasEmpty;
   logic             push;
   logic             pushOverflow;
   logic             popUnderflow;
   logic [SPW-1:0]   spMinusOne;
   logic [IDXW-1:0]  pushIdx;
   logic [IDXW-1:0]  popIdx;

   assign rasFull      = (sp_q == SPW'(RAS_DEPTH));
   assign rasEmpty     = (sp_q == '0);
   assign spMinusOne   = sp_q - SPW'(1);
   assign pushIdx      = sp_q[IDXW-1:0];
   assign popIdx       = spMinusOne[IDXW-1:0];

   // ret only counts when nothing of higher priority is asserted, which
   // also makes a simultaneous call win over ret.
   assign retReq       = ~clear & ~load & ~call & ret;
   assign pop          = retReq & ~rasEmpty;
   assign popUnderflow = retReq & rasEmpty;
   assign push         = ~clear & call & ~rasFull;
   assign pushOverflow = ~clear & call & rasFull;
   assign popData      = ras_q[popIdx];

   // Stack pointer and sticky error next-state. A full push is dropped but
   // the redirect still happens; an empty pop leaves the PC alone.
   always_comb begin
      sp_d     = sp_q;
      rasErr_d = rasErr_q;
      if (clear) begin
         sp_d     = '0;
         rasErr_d = 1'b0;
      end else begin
         if (push) begin
            sp_d = sp_q + SPW'(1);
         end else if (pop) begin
            sp_d = spMinusOne;
         end
         if (pushOverflow || popUnderflow) begin
            rasErr_d = 1'b1;
         end
      end
   end

   // Pointer and error flag reset asynchronously; reset empties the stack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp_q     <= '0;
         rasErr_q <= 1'b0;
      end else begin
         sp_q     <= sp_d;
         rasErr_q <= rasErr_d;
      end
   end

   // Stack storage needs no reset: entries are only read below the pointer.
   always_ff @(posedge clk) begin
      if (push) begin
         ras_q[pushIdx] <= pcPlusOne;
      end
   end

   assign ras_err = rasErr_q;

`else

   logic unusedRet;

   // Without the stack, ret has no effect and call already acts as load.
   assign unusedRet = ret;
   assign retReq    = 1'b0;
   assign pop       = 1'b0;
   assign popData   = '0;
   assign ras_err   = 1'b0;

`endif

   // Advance needs a real handshake and no higher-priority request; an
   // accept coinciding with a redirect is simply dropped.
   assign advance = ~clear & ~load & ~call & ~retReq & accept & inc;

   // State register: BOOT out of reset, one bubble before fetching.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. Any redirect (including a successful pop) forces a
   // one-cycle FLUSH bubble even if we were already in BOOT or FLUSH.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = BOOT;
      end else if (redirect || pop) begin
         state_d = FLUSH;
      end else begin
         unique case (state_q)
            BOOT:    state_d = RUN;
            FLUSH:   state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
         endcase
      end
   end

   // Output logic: only RUN presents a fetchable address.
   always_comb begin
      out_valid = (state_q == RUN);
      out       = pc_q;
      wrap      = wrap_q;
   end

   // PC and wrap next-state in priority order. wrap is sticky and only a
   // real sequential advance past FFFF sets it; load never clears it.
   always_comb begin
      pc_d   = pc_q;
      wrap_d = wrap_q;
      if (clear) begin
         pc_d   = RESET_VECTOR;
         wrap_d = 1'b0;
      end else if (redirect) begin
         pc_d = load_addr;
      end else if (pop) begin
         pc_d = popData;
      end else if (advance) begin
         pc_d = pcPlusOne;
         if (pcCarry) begin
            wrap_d = 1'b1;
         end
      end
   end

   // PC and wrap registers; reset takes effect immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q   <= RESET_VECTOR;
         wrap_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         wrap_q <= wrap_d;
      end
   end

endmodule
